memory_unit: RTL and testbench
==============================

# memory_unit

Data memory of the single-cycle RISC datapath: a word-organised RAM sitting behind the ALU result bus in the memory stage. Writes are synchronous to `clk` when `MemWrite` is high. Reads are combinational when `MemRead` is high. An asynchronous active-high reset clears the whole array to zero.

## Interface
Parameters:
- `DATA_W`, default 32: data word width.
- `ADDR_W`, default 32: address bus width.
- `DEPTH_LOG2`, default 8: log2 of the word count (256 words = 1 KiB).

Ports:
- `clk`  in  1  single clock; writes occur on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all words.
- `address`  in  32  byte address from the ALU.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data.
- `MemWrite`  in  1  write enable.
- `MemRead`  in  1  read enable.

Declaration order for positional instantiation: `address, write_data, read_data, MemWrite, MemRead, clk, rst`.

## Operation
- Storage is `2**DEPTH_LOG2` words of `DATA_W` bits.
- Word index is `address[DEPTH_LOG2+1:2]`.
  - `address[1:0]` is ignored; there is no byte or halfword access and no misalignment trap.
  - Bits above `DEPTH_LOG2+1` are ignored, so addresses alias (wrap) modulo 1 KiB.
- Write: on a rising edge of `clk` with `MemWrite=1` and `rst=0`, `mem[index] <= write_data`. `MemRead` has no effect on writes.
- Read: `read_data = mem[index]` combinationally while `MemRead=1`. While `MemRead=0`, `read_data = 0`.
- Reset: while `rst=1`, every word is 0 immediately, independent of `clk`, and writes are blocked.
  - `read_data` is therefore 0 during reset, whatever `MemRead` is.
- No other state; no handshake and no busy signal. Every access completes in the same cycle.

## Timing
- Write latency: data is visible in `mem` right after the enabling rising edge.
- Read latency: zero cycles. `read_data` follows `address`, `MemRead` and the array contents combinationally.
- Read and write in the same cycle to the same word:
  - Before the edge, `read_data` shows the old contents.
  - After the edge, it shows `write_data`.
  - There is no internal bypass.
- Reset asserted mid-cycle: the array and `read_data` go to 0 at once. A write edge coinciding with `rst=1` is discarded.
- Reset deassertion: the first rising edge with `rst=0` may write.
- Reset value of the only output, `read_data`: 0.

## Structure
- Shared package `memory_pkg` holds:
  - constants `DATA_W=32`, `ADDR_W=32`, `DEPTH_LOG2=8`;
  - a `word_t` typedef of `DATA_W` bits.
- One natural sub-module: `dmem_array`. It holds the storage with async clear, a synchronous write port and an async read port.
- `memory_unit` wraps `dmem_array` and adds:
  - index extraction from `address`;
  - `MemRead` gating of `read_data` (output 0 when not reading).

## Test plan
- Reset then read: assert `rst`, release, then `MemRead=1` at addresses 0x0, 0x0A and 0x3FC -> `read_data=0` each time.
- Write/read-back: at `address=0x0A`, `write_data=0x00000001`, `MemWrite=1`, one rising edge; then `MemWrite=0`, `MemRead=1` -> `read_data=0x00000001`. Holding `MemRead=1` for another cycle -> still 0x00000001.
- Read gating and word granularity:
  - With `MemRead=0` at the same address -> `read_data=0`.
  - With `MemRead=1`, addresses 0x08, 0x09 and 0x0B (same word as 0x0A) -> `read_data=0x00000001`.
- Same-cycle read/write: word 0x10 holds 0xAAAA5555. Set `MemRead=MemWrite=1` with `write_data=0x12345678`.
  - Before the edge -> `read_data=0xAAAA5555`.
  - After the edge -> `read_data=0x12345678`.
- Aliasing: write 0xDEADBEEF at 0x00000404 -> reading 0x00000004 returns 0xDEADBEEF.
- Async reset mid-operation:
  - With data stored and `MemRead=1`, pulse `rst` between clock edges -> `read_data` drops to 0 immediately, and all previously written words read 0 afterwards.
  - A write attempted at an edge while `rst=1` -> the target word still reads 0.

Source files
------------

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared constants and types for the data memory
package memory_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int DEPTH_LOG2 = 8;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with async clear, sync write, async read
module dmem_array
    import memory_pkg::*;
#(
    parameter int DATA_W     = memory_pkg::DATA_W,
    parameter int DEPTH_LOG2 = memory_pkg::DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Reset wipes every word at once; otherwise a single word is written per enabled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read port has no register: it follows the address and the array contents
    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - data memory of the single-cycle datapath memory stage
module memory_unit
    import memory_pkg::*;
#(
    parameter int DATA_W     = memory_pkg::DATA_W,
    parameter int ADDR_W     = memory_pkg::ADDR_W,
    parameter int DEPTH_LOG2 = memory_pkg::DEPTH_LOG2
) (
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              clk,
    input  logic              rst
);

    logic [DEPTH_LOG2-1:0] w_index;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_unused_addr;

    // Byte address to word index: low two bits select a byte we never use, high bits alias
    assign w_index       = address[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{address[ADDR_W-1:DEPTH_LOG2+2], address[1:0]};

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (MemWrite),
        .i_addr  (w_index),
        .i_wdata (write_data),
        .o_rdata (w_rdata)
    );

    // Load bus is driven only while a read is requested
    always_comb begin
        read_data = '0;
        if (MemRead) begin
            read_data = w_rdata;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - self-checking bench for memory_unit
module tb_memory_unit;

    logic [31:0] address    = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        MemWrite   = 1'b0;
    logic        MemRead    = 1'b0;
    logic        clk        = 1'b0;
    logic        rst        = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] model [int];

    memory_unit dut (
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .clk        (clk),
        .rst        (rst)
    );

    always #5 clk = ~clk;

    function automatic int word_of(input logic [31:0] a);
        return int'(a % 32'd1024) / 4;
    endfunction

    function automatic logic [31:0] expected_read();
        if (rst || !MemRead) return 32'h0;
        if (model.exists(word_of(address))) return model[word_of(address)];
        return 32'h0;
    endfunction

    always @(posedge rst) model.delete();

    always @(posedge clk) begin
        if (!rst && MemWrite) model[word_of(address)] = write_data;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (read_data !== expected_read()) begin
                errors++;
                $display("FAIL cycle_model t=%0t addr=%h got=%h want=%h", $time, address, read_data, expected_read());
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re);
        address    = a;
        write_data = wd;
        MemWrite   = we;
        MemRead    = re;
    endtask

    task automatic lit(input string name, input logic [31:0] want);
        #1;
        checks++;
        if (read_data !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, read_data, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        drive(32'h0, 32'h0, 1'b0, 1'b1);   lit("reset_rd_0",   32'h0);
        drive(32'h0A, 32'h0, 1'b0, 1'b1);  lit("reset_rd_0a",  32'h0);
        drive(32'h3FC, 32'h0, 1'b0, 1'b1); lit("reset_rd_3fc", 32'h0);
        tick();

        drive(32'h0A, 32'h1, 1'b1, 1'b0);
        tick();
        drive(32'h0A, 32'h0, 1'b0, 1'b1);  lit("wr_rd_0a", 32'h1);
        tick();
        lit("rd_hold_0a", 32'h1);
        drive(32'h0A, 32'h0, 1'b0, 1'b0);  lit("rd_gate_off", 32'h0);
        drive(32'h08, 32'h0, 1'b0, 1'b1);  lit("word_08", 32'h1);
        drive(32'h09, 32'h0, 1'b0, 1'b1);  lit("word_09", 32'h1);
        drive(32'h0B, 32'h0, 1'b0, 1'b1);  lit("word_0b", 32'h1);
        tick();

        drive(32'h10, 32'hAAAA5555, 1'b1, 1'b0);
        tick();
        drive(32'h10, 32'h12345678, 1'b1, 1'b1); lit("rw_before_edge", 32'hAAAA5555);
        tick();
        lit("rw_after_edge", 32'h12345678);

        drive(32'h404, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        drive(32'h4, 32'h0, 1'b0, 1'b1);   lit("alias_404_4", 32'hDEADBEEF);
        drive(32'hFFFFFFFC, 32'h5A5A0F0F, 1'b1, 1'b0);
        tick();
        drive(32'h3FC, 32'h0, 1'b0, 1'b1); lit("alias_top_3fc", 32'h5A5A0F0F);
        tick();

        drive(32'h10, 32'h0, 1'b0, 1'b1);  lit("pre_rst_10", 32'h12345678);
        rst = 1'b1;                        lit("mid_rst_drop", 32'h0);
        rst = 1'b0;                        lit("post_rst_10", 32'h0);
        drive(32'h0A, 32'h0, 1'b0, 1'b1);  lit("post_rst_0a", 32'h0);
        drive(32'h4, 32'h0, 1'b0, 1'b1);   lit("post_rst_4", 32'h0);
        tick();

        drive(32'h20, 32'hCAFEF00D, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(32'h20, 32'h0, 1'b0, 1'b1);  lit("wr_blocked_rst", 32'h0);
        drive(32'h24, 32'h00000005, 1'b1, 1'b0);
        tick();
        drive(32'h24, 32'h0, 1'b0, 1'b1);  lit("first_edge_wr", 32'h5);
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
